// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback vs. queued external writes,
// with a pending-write scoreboard for read hazards and a starvation-bounding stall.
module rf_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_wr,
  input  logic [4:0]               core_rd,
  input  logic [XLEN-1:0]          core_data,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  input  logic [4:0]               ext_rd,
  input  logic [XLEN-1:0]          ext_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               raddr1,
  input  logic [4:0]               raddr2,
  output logic                     hazard,
  output logic                     core_stall,
  output logic                     rf_wr,
  output logic [4:0]               rf_wr_add,
  output logic [XLEN-1:0]          rf_wr_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic [31:0]     pending, pending_next;

  logic full, empty, push, pop, core_req, core_win;
  logic [4:0] head_rd;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign ext_ready = !full && !rst;
  assign head_rd   = mem_rd[rd_ptr];

  // x0 handshakes complete but never occupy a slot
  assign push      = ext_valid && ext_ready && (ext_rd != '0);
  assign core_req  = core_wr && (core_rd != '0);
  assign core_stall = (starve_cnt == LIMIT);

  // Pop on a forced stall, or whenever the core has nothing to write
  assign pop       = !empty && (core_stall || !core_req);
  assign core_win  = core_req && !pop;

  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_rd[wr_ptr]   <= ext_rd;
        mem_data[wr_ptr] <= ext_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
    end else if (core_win && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Clear first, then set, so a same-cycle issue to the popped register wins
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign hazard = ((raddr1 != '0) && pending[raddr1]) ||
                  ((raddr2 != '0) && pending[raddr2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr      <= 1'b0;
      rf_wr_add  <= '0;
      rf_wr_data <= '0;
    end else if (pop) begin
      rf_wr      <= 1'b1;
      rf_wr_add  <= head_rd;
      rf_wr_data <= mem_data[rd_ptr];
    end else if (core_win) begin
      rf_wr      <= 1'b1;
      rf_wr_add  <= core_rd;
      rf_wr_data <= core_data;
    end else begin
      rf_wr      <= 1'b0;
    end
  end

endmodule
